// File: rtl/dma_mm2s_axis_sink.sv
// Receiving end of the MM2S AXI4-Stream: buffers beats in a show-ahead FIFO,
// counts packets and bytes, and checks each packet's beat count against the
// programmed length.
module dma_mm2s_axis_sink #(
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DW-1:0]    s_axis_tdata,
  input  logic [DW/8-1:0]  s_axis_tkeep,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [7:0]       expected_len_i,
  input  logic             rd_en_i,
  output logic             rd_valid_o,
  output logic [DW-1:0]    rd_data_o,
  output logic             rd_last_o,
  output logic [CNT_W-1:0] pkt_cnt_o,
  output logic [31:0]      byte_cnt_o,
  output logic             len_err_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int KW = DW / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0]    PTR_ONE = 1;
  localparam logic [AW:0]      CNT_ONE = 1;
  localparam logic [AW:0]      CNT_FULL = FIFO_DEPTH;
  localparam logic [CNT_W-1:0] PKT_ONE = 1;

  typedef enum logic {IDLE, RECV} state_t;

  state_t            state_q, state_d;
  logic [DW:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic [7:0]        exp_len_q, exp_len_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [$clog2(KW):0] keep_bytes;
  logic [8:0]        beat_next;
  logic [32:0]       byte_sum;
  logic              full, empty, accept, push, pop;
  logic              set_err, pkt_inc, done_d;

  // full comes from the registered count only, so a same-cycle pop never raises tready
  assign full          = (count_q == CNT_FULL);
  assign empty         = (count_q == '0);
  assign s_axis_tready = (state_q == RECV) && !full;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign push          = accept && !clear_i;
  assign pop           = rd_en_i && !empty && !clear_i;
  assign beat_next     = {1'b0, beat_cnt_q} + 9'd1;
  assign byte_sum      = {1'b0, byte_cnt_o} + 33'(keep_bytes);
  assign busy_o        = (state_q == RECV);
  assign rd_valid_o    = !empty;
  // Head is gated by empty so the read port reads 0 after reset, not stale memory
  assign {rd_last_o, rd_data_o} = empty ? '0 : mem[rd_ptr_q];

  // Number of qualified bytes in the current beat
  always_comb begin
    keep_bytes = '0;
    for (int i = 0; i < KW; i++) begin
      keep_bytes = keep_bytes + ($bits(keep_bytes))'(s_axis_tkeep[i]);
    end
  end

  // Packet FSM: next state, beat counting and length-check decisions
  always_comb begin
    // NOTE: every output gets a default first; a path that leaves one unassigned would infer a latch.
    state_d    = state_q;
    exp_len_d  = exp_len_q;
    beat_cnt_d = beat_cnt_q;
    set_err    = 1'b0;
    pkt_inc    = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d    = RECV;
          exp_len_d  = expected_len_i;
          beat_cnt_d = '0;
        end
      end
      RECV: begin
        if (accept) begin
          if (s_axis_tlast) begin
            pkt_inc    = 1'b1;
            done_d     = 1'b1;
            set_err    = (exp_len_q != '0) && (beat_next != {1'b0, exp_len_q});
            beat_cnt_d = '0;
            if (enable_i) exp_len_d = expected_len_i;
            else          state_d   = IDLE;
          end else begin
            set_err    = (exp_len_q != '0) && (beat_next > {1'b0, exp_len_q});
            beat_cnt_d = (beat_cnt_q == 8'hFF) ? 8'hFF : beat_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, counters and status; clear overrides everything else
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q    <= IDLE;
      exp_len_q  <= '0;
      beat_cnt_q <= '0;
      pkt_cnt_o  <= '0;
      byte_cnt_o <= '0;
      len_err_o  <= 1'b0;
      done_o     <= 1'b0;
    end else if (clear_i) begin
      state_q    <= IDLE;
      exp_len_q  <= '0;
      beat_cnt_q <= '0;
      pkt_cnt_o  <= '0;
      byte_cnt_o <= '0;
      len_err_o  <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_len_q  <= exp_len_d;
      beat_cnt_q <= beat_cnt_d;
      done_o     <= done_d;
      if (set_err) len_err_o <= 1'b1;
      if (pkt_inc) pkt_cnt_o <= pkt_cnt_o + PKT_ONE;
      if (accept)  byte_cnt_o <= byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage: {tlast, tdata} per accepted beat
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; the pointers and count define which entries are valid.
    if (push) mem[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
  end

endmodule

// File: tb/tb_dma_mm2s_axis_sink.sv
// Self-checking bench for dma_mm2s_axis_sink with a queue-based reference model.
module tb_dma_mm2s_axis_sink;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    tdata;
  logic [DW/8-1:0]  tkeep;
  logic             tlast, tvalid, tready;
  logic             enable, clear, rd_en;
  logic [7:0]       exp_len;
  logic             rd_valid, rd_last, len_err, busy, done;
  logic [DW-1:0]    rd_data;
  logic [CNT_W-1:0] pkt_cnt;
  logic [31:0]      byte_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state (packet-level view of the sink)
  logic [DW:0] mq[$];
  bit          m_recv, m_err, m_done;
  int          m_exp, m_beats, m_pkt;
  longint      m_bytes;

  dma_mm2s_axis_sink #(.DW(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .enable_i(enable), .clear_i(clear), .expected_len_i(exp_len),
    .rd_en_i(rd_en), .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_last_o(rd_last),
    .pkt_cnt_o(pkt_cnt), .byte_cnt_o(byte_cnt), .len_err_o(len_err),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_recv = 0; m_err = 0; m_done = 0;
    m_exp = 0; m_beats = 0; m_pkt = 0; m_bytes = 0;
  endtask

  // One clock of stimulus: check pre-edge outputs, advance the model, check post-edge outputs
  task automatic cycle(output bit acc);
    bit exp_rdy, pop_ok;
    #1;
    exp_rdy = m_recv && (mq.size() < DEPTH);
    checks++;
    if (tready !== exp_rdy) begin
      errors++; $display("FAIL tready got %0b exp %0b @%0t", tready, exp_rdy, $time);
    end
    checks++;
    if (rd_valid !== (mq.size() != 0)) begin
      errors++; $display("FAIL rd_valid got %0b exp %0b @%0t", rd_valid, mq.size() != 0, $time);
    end
    if (mq.size() != 0) begin
      checks++;
      if ({rd_last, rd_data} !== mq[0]) begin
        errors++; $display("FAIL rd_head got %h exp %h @%0t", {rd_last, rd_data}, mq[0], $time);
      end
    end
    acc = tvalid && exp_rdy && !clear;
    pop_ok = rd_en && (mq.size() != 0);
    if (clear) begin
      model_reset();
    end else begin
      m_done = 0;
      if (pop_ok) void'(mq.pop_front());
      if (!m_recv) begin
        if (enable) begin m_recv = 1; m_exp = exp_len; m_beats = 0; end
      end else if (acc) begin
        mq.push_back({tlast, tdata});
        m_bytes = m_bytes + $countones(tkeep);
        if (m_bytes > 64'hFFFF_FFFF) m_bytes = 64'hFFFF_FFFF;
        m_beats++;
        if (m_exp != 0 && m_beats > m_exp) m_err = 1;
        if (tlast) begin
          m_pkt++; m_done = 1;
          if (m_exp != 0 && m_beats != m_exp) m_err = 1;
          m_beats = 0;
          if (enable) m_exp = exp_len; else m_recv = 0;
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (pkt_cnt !== CNT_W'(m_pkt)) begin
      errors++; $display("FAIL pkt_cnt got %0d exp %0d @%0t", pkt_cnt, CNT_W'(m_pkt), $time);
    end
    checks++;
    if (byte_cnt !== 32'(m_bytes)) begin
      errors++; $display("FAIL byte_cnt got %0d exp %0d @%0t", byte_cnt, m_bytes, $time);
    end
    checks++;
    if (len_err !== m_err) begin
      errors++; $display("FAIL len_err got %0b exp %0b @%0t", len_err, m_err, $time);
    end
    checks++;
    if (done !== m_done) begin
      errors++; $display("FAIL done got %0b exp %0b @%0t", done, m_done, $time);
    end
    checks++;
    if (busy !== m_recv) begin
      errors++; $display("FAIL busy got %0b exp %0b @%0t", busy, m_recv, $time);
    end
  endtask

  task automatic idle_inputs();
    tvalid = 0; tlast = 0; tdata = '0; tkeep = '0; rd_en = 0; clear = 0;
  endtask

  task automatic do_clear();
    bit acc;
    idle_inputs(); enable = 0; clear = 1;
    cycle(acc);
    clear = 0;
  endtask

  // Sends one n-beat packet; keep_mode 0: all F, 1: random, 2: last beat 4'b0011
  task automatic send_pkt(int n, int exp, int vprob, int rprob, int keep_mode, bit en_rand);
    int idx = 0;
    int budget = 0;
    bit acc;
    exp_len = 8'(exp);
    while (idx < n && budget < 2000) begin
      tvalid = ($urandom_range(99) < vprob);
      tdata  = $urandom;
      tkeep  = (keep_mode == 1) ? 4'($urandom) : ((keep_mode == 2 && idx == n - 1) ? 4'b0011 : 4'hF);
      tlast  = (idx == n - 1);
      rd_en  = ($urandom_range(99) < rprob);
      enable = (idx == 0 || !en_rand) ? 1'b1 : 1'($urandom);
      cycle(acc);
      if (acc) idx++;
      budget++;
    end
    tvalid = 0; tlast = 0; rd_en = 0;
    checks++;
    if (idx != n) begin
      errors++; $display("FAIL send_timeout got %0d beats exp %0d", idx, n);
    end
  endtask

  task automatic drain();
    int budget = 0;
    bit acc;
    tvalid = 0; rd_en = 1;
    while (mq.size() != 0 && budget < 100) begin cycle(acc); budget++; end
    rd_en = 0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL drain rd_valid got %0b exp 0", rd_valid);
    end
  endtask

  task automatic test_reset();
    idle_inputs(); enable = 0; exp_len = 0;
    rst = 1;
    #2;
    checks++;
    if ({tready, rd_valid, pkt_cnt, byte_cnt, len_err, busy, done, rd_last, rd_data} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero outputs");
    end
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_basic();
    do_clear();
    send_pkt(4, 4, 100, 100, 0, 0);
    drain();
    checks++;
    if (pkt_cnt !== 4'd1 || byte_cnt !== 32'd16 || len_err !== 1'b0) begin
      errors++; $display("FAIL t1_totals got pkt=%0d bytes=%0d err=%0b exp 1 16 0", pkt_cnt, byte_cnt, len_err);
    end
  endtask

  task automatic test_partial_keep();
    do_clear();
    send_pkt(3, 3, 100, 0, 2, 0);
    drain();
    checks++;
    if (pkt_cnt !== 4'd1 || byte_cnt !== 32'd10 || len_err !== 1'b0) begin
      errors++; $display("FAIL t2_totals got pkt=%0d bytes=%0d err=%0b exp 1 10 0", pkt_cnt, byte_cnt, len_err);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] words [20];
    int idx = 0;
    int budget = 0;
    bit acc;
    for (int i = 0; i < 20; i++) words[i] = $urandom;
    do_clear();
    enable = 1; exp_len = 8'd20;
    cycle(acc);
    for (int c = 0; c < 25; c++) begin
      tvalid = 1; tkeep = 4'hF; tdata = words[idx]; tlast = (idx == 19);
      cycle(acc);
      if (acc) idx++;
    end
    checks++;
    if (idx != 16 || tready !== 1'b0) begin
      errors++; $display("FAIL t3_full got accepts=%0d tready=%0b exp 16 0", idx, tready);
    end
    rd_en = 1;
    cycle(acc);
    rd_en = 0;
    checks++;
    if (tready !== 1'b1) begin
      errors++; $display("FAIL t3_pop_ready got %0b exp 1", tready);
    end
    rd_en = 1;
    while ((idx < 20 || mq.size() != 0) && budget < 200) begin
      tvalid = (idx < 20); tdata = (idx < 20) ? words[idx] : '0; tlast = (idx == 19);
      cycle(acc);
      if (acc) idx++;
      budget++;
    end
    idle_inputs();
    checks++;
    if (idx != 20 || pkt_cnt !== 4'd1 || byte_cnt !== 32'd80) begin
      errors++; $display("FAIL t3_totals got beats=%0d pkt=%0d bytes=%0d exp 20 1 80", idx, pkt_cnt, byte_cnt);
    end
  endtask

  task automatic test_len_err();
    int idx = 0;
    int budget = 0;
    bit acc;
    do_clear();
    send_pkt(2, 4, 100, 100, 0, 0);
    checks++;
    if (len_err !== 1'b1 || pkt_cnt !== 4'd1) begin
      errors++; $display("FAIL t4_short got err=%0b pkt=%0d exp 1 1", len_err, pkt_cnt);
    end
    do_clear();
    enable = 1; exp_len = 8'd2; rd_en = 1;
    while (idx < 5 && budget < 50) begin
      tvalid = 1; tkeep = 4'hF; tdata = $urandom; tlast = (idx == 4);
      cycle(acc);
      if (acc) begin
        idx++;
        if (idx == 2) begin
          checks++;
          if (len_err !== 1'b0) begin errors++; $display("FAIL t4_beat2 got %0b exp 0", len_err); end
        end
        if (idx == 3) begin
          checks++;
          if (len_err !== 1'b1) begin errors++; $display("FAIL t4_beat3 got %0b exp 1", len_err); end
        end
      end
      budget++;
    end
    idle_inputs();
    checks++;
    if (pkt_cnt !== 4'd1 || idx != 5) begin
      errors++; $display("FAIL t4_long got pkt=%0d beats=%0d exp 1 5", pkt_cnt, idx);
    end
  endtask

  task automatic test_mid_reset();
    int idx = 0;
    bit acc;
    do_clear();
    enable = 1; exp_len = 8'd4;
    while (idx < 2 && m_beats < 10) begin
      tvalid = 1; tkeep = 4'hF; tdata = $urandom; tlast = 0;
      cycle(acc);
      if (acc) idx++;
    end
    #3;
    rst = 1;
    #1;
    checks++;
    if ({tready, rd_valid, pkt_cnt, byte_cnt, len_err, busy, done, rd_last, rd_data} !== '0) begin
      errors++; $display("FAIL t5_reset got tready=%0b bytes=%0d busy=%0b", tready, byte_cnt, busy);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 0; enable = 0;
    for (int c = 0; c < 4; c++) begin
      tvalid = 1; tdata = $urandom;
      cycle(acc);
      checks++;
      if (acc) begin errors++; $display("FAIL t5_no_accept got accept without enable"); end
    end
    send_pkt(4, 4, 100, 100, 0, 0);
    drain();
  endtask

  task automatic test_clear_accept();
    bit acc;
    do_clear();
    enable = 1; exp_len = 8'd3;
    cycle(acc);
    tvalid = 1; tkeep = 4'hF; tdata = $urandom; clear = 1;
    cycle(acc);
    idle_inputs();
    checks++;
    if (byte_cnt !== 32'd0 || rd_valid !== 1'b0 || busy !== 1'b0 || tready !== 1'b0) begin
      errors++; $display("FAIL t6_clear got bytes=%0d rd_valid=%0b busy=%0b tready=%0b exp 0",
                         byte_cnt, rd_valid, busy, tready);
    end
    send_pkt(3, 3, 100, 100, 0, 0);
    drain();
    checks++;
    if (pkt_cnt !== 4'd1 || byte_cnt !== 32'd12 || len_err !== 1'b0) begin
      errors++; $display("FAIL t6_after got pkt=%0d bytes=%0d err=%0b exp 1 12 0", pkt_cnt, byte_cnt, len_err);
    end
  endtask

  task automatic test_random();
    int n;
    do_clear();
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, 6);
      send_pkt(n, $urandom_range(0, 6), 70, 60, 1, 1);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial_keep();
    test_backpressure();
    test_len_err();
    test_mid_reset();
    test_clear_accept();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
